// File: rtl/sequential_fifo.sv
// -----------------------------------------------------------------------------
// sequential_fifo
//   Circular request-driven FIFO of DEPTH words. Each request input is a level;
//   one word is written (or popped) per assertion, and a served request must be
//   seen low for at least one clock before it can act again. A request that is
//   blocked (full for writes, empty for reads) stays pending and is served on
//   the first edge that allows it. Same-edge read+write is supported; an empty
//   FIFO never passes a word straight through.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset of pointers/count/arming
//   clear          synchronous flush; requests on the same edge are ignored
//   request_write  level write request
//   request_read   level read (pop) request
//   data_in        word captured on an accepted write
//   data_out       oldest stored word, 0 when empty
//   correct_read   at least one word stored
//   full           DEPTH words stored
//   count          number of words stored
// -----------------------------------------------------------------------------
module sequential_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         request_write,
  input  logic                         request_read,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         correct_read,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_wr_armed;
  logic                  r_rd_armed;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_full;
  logic                  w_nonempty;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_nonempty = (r_count != '0);

  // Read qualification uses the pre-edge count, so an empty FIFO with both
  // requests accepts only the write; the read stays armed for the next edge.
  assign w_wr_acc = request_write && r_wr_armed && !w_full     && !clear;
  assign w_rd_acc = request_read  && r_rd_armed && w_nonempty  && !clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wr_armed <= 1'b1;
      r_rd_armed <= 1'b1;
    end else begin
      // Re-arm whenever the request is seen low; disarm on the serving edge.
      if (!request_write)  r_wr_armed <= 1'b1;
      else if (w_wr_acc)   r_wr_armed <= 1'b0;

      if (!request_read)   r_rd_armed <= 1'b1;
      else if (w_rd_acc)   r_rd_armed <= 1'b0;

      if (clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_wr_acc && !w_rd_acc)      r_count <= r_count + CW'(1);
        else if (w_rd_acc && !w_wr_acc) r_count <= r_count - CW'(1);
      end
    end
  end

  // Storage has no reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !reset) r_mem[r_wr_ptr] <= data_in;
  end

  assign full         = w_full;
  assign correct_read = w_nonempty;
  assign count        = r_count;
  assign data_out     = w_nonempty ? r_mem[r_rd_ptr] : '0;

endmodule
